// File: rtl/sdp_pipe_impl_if.sv
// sdp_pipe_impl_if: operand/result valid-ready bundle for sdp_pipe_impl.
// out_parity is present only when SDP_PARITY_EN is defined.
interface sdp_pipe_impl_if #(parameter int W = 8, parameter int CNT_W = 16);
   logic in_valid, in_ready, ctl_a, ctl_b, out_valid, out_ready;
   logic [W-1:0] a, b, c, out_data;
   logic [CNT_W-1:0] out_count;
`ifdef SDP_PARITY_EN
   logic out_parity;
`endif
   modport master (
      output in_valid, ctl_a, ctl_b, a, b, c, out_ready,
      input in_ready, out_valid, out_data, out_count
`ifdef SDP_PARITY_EN
      , input out_parity
`endif
   );
   modport slave (
      input in_valid, ctl_a, ctl_b, a, b, c, out_ready,
      output in_ready, out_valid, out_data, out_count
`ifdef SDP_PARITY_EN
      , output out_parity
`endif
   );
endinterface

// File: rtl/sdp_pipe_impl.sv
// sdp_pipe_impl: 3-stage valid/ready pipeline of the 8-bit select/datapath function.
// Optional out_parity and its self-check are enabled by SDP_PARITY_EN.
module sdp_pipe_impl #(parameter int W = 8, parameter int CNT_W = 16) (
   input logic clk,
   input logic reset_n,
   sdp_pipe_impl_if.slave bus
);
   logic v1, v2, v3, adv1, adv2, adv3, ca1, cb1, ca2;
   logic [W-1:0] p, c1, q, r, r_n;
   logic [CNT_W-1:0] cnt;
   // each stage may load when it is empty or the stage below is moving
   assign adv3 = !v3 | bus.out_ready;
   assign adv2 = !v2 | adv3;
   assign adv1 = !v1 | adv2;
   assign bus.in_ready = reset_n & adv1;
   assign bus.out_valid = v3;
   assign bus.out_data = r;
   assign bus.out_count = cnt;
   assign r_n = ca2 ? {q[W-2:0], q[W-1]} : q;
`ifdef SDP_PARITY_EN
   logic par;
   assign bus.out_parity = par;
   always_ff @(posedge clk)
      if (!reset_n) par <= 1'b0;
      else if (adv3 & v2) par <= ^r_n;
   assert property (@(posedge clk) disable iff (!reset_n) bus.out_valid |-> bus.out_parity == ^bus.out_data);
`endif
   always_ff @(posedge clk)
      if (!reset_n) begin
         {v1, v2, v3, ca1, cb1, ca2} <= '0;
         p <= '0;
         c1 <= '0;
         q <= '0;
         r <= '0;
         cnt <= '0;
      end else begin
         if (adv1) v1 <= bus.in_valid;
         if (adv1 & bus.in_valid) begin
            p <= bus.ctl_a ? bus.a + bus.b : bus.a - bus.b;
            c1 <= bus.c;
            ca1 <= bus.ctl_a;
            cb1 <= bus.ctl_b;
         end
         if (adv2) v2 <= v1;
         if (adv2 & v1) begin
            q <= cb1 ? p * c1 : p ^ c1;
            ca2 <= ca1;
         end
         if (adv3) v3 <= v2;
         if (adv3 & v2) r <= r_n;
         if (v3 & bus.out_ready) cnt <= cnt + 1'b1;
      end
endmodule

// File: tb/tb_sdp_pipe_impl.sv
// tb_sdp_pipe_impl: scoreboard bench for sdp_pipe_impl with a behavioural reference model.
module tb_sdp_pipe_impl;
   logic clk = 0, reset_n = 0;
   always #5 clk = ~clk;
   sdp_pipe_impl_if bus ();
   sdp_pipe_impl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   int tests = 0, fails = 0, delivered = 0;
   logic [7:0] expq[$];
   logic [15:0] exp_cnt = 0;
   bit wrap_pend = 0, prev_stall = 0;
   logic [7:0] prev_data = 0;

   function automatic logic [7:0] model(bit ca, bit cb, int x, int y, int z);
      int p, q;
      p = ca ? (x + y) % 256 : (x - y + 256) % 256;
      q = cb ? (p * z) % 256 : p ^ z;
      return ca ? 8'((q * 2) % 256 + q / 128) : 8'(q);
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
      end
   endtask

   task automatic set_ops(input bit ca, input bit cb, input logic [7:0] x, y, z);
      bus.ctl_a = ca;
      bus.ctl_b = cb;
      bus.a = x;
      bus.b = y;
      bus.c = z;
   endtask

   task automatic set_rand();
      set_ops(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   // single accept into an idle pipe; lat = negedges after the accepting edge until out_valid
   task automatic one(input bit ca, input bit cb, input logic [7:0] x, y, z, output int lat);
      @(posedge clk); #2;
      set_ops(ca, cb, x, y, z);
      bus.in_valid = 1;
      @(posedge clk); #2;
      bus.in_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // stimulus side of the scoreboard
   always @(negedge clk)
      if (!reset_n) expq.delete();
      else if (bus.in_valid && bus.in_ready)
         expq.push_back(model(bus.ctl_a, bus.ctl_b, int'(bus.a), int'(bus.b), int'(bus.c)));

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_cnt = 0;
         delivered = 0;
         prev_stall = 0;
         wrap_pend = 0;
      end else begin
         if (wrap_pend) begin
            chk("wrap", int'(bus.out_count), 0);
            wrap_pend = 0;
         end
         if (prev_stall) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(prev_data));
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", int'(expq.size() > 0), 1);
            if (expq.size() > 0) chk("data", int'(bus.out_data), int'(expq.pop_front()));
            chk("count", int'(bus.out_count), int'(exp_cnt));
            exp_cnt++;
            delivered++;
            if (exp_cnt == 0) wrap_pend = 1;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data = bus.out_data;
      end
   end

   initial begin
      int lat, acc, gaps, seen;
      logic [15:0] base;
      bus.in_valid = 0;
      bus.out_ready = 1;
      set_ops(0, 0, 0, 0, 0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_in_ready", int'(bus.in_ready), 0);
      end
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_count", int'(bus.out_count), 0);
      @(posedge clk); #2;
      reset_n = 1;
      @(negedge clk);
      chk("post_rst_in_ready", int'(bus.in_ready), 1);

      one(1, 1, 8'd10, 8'd3, 8'd5, lat);
      chk("lat1", lat, 3);
      chk("dir1", int'(bus.out_data), 8'h82);
      one(0, 0, 8'd3, 8'd5, 8'hFF, lat);
      chk("lat2", lat, 3);
      chk("dir2", int'(bus.out_data), 8'h01);
      one(1, 1, 8'hFF, 8'd2, 8'd3, lat);
      chk("lat3", lat, 3);
      chk("dir3", int'(bus.out_data), 8'h06);

      // backpressure: fill with out_ready low, then release
      @(posedge clk); #2;
      base = exp_cnt;
      bus.out_ready = 0;
      set_rand();
      bus.in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_open", int'(bus.in_ready), 1);
         @(posedge clk); #2;
         set_rand();
      end
      repeat (3) begin
         @(negedge clk);
         chk("bp_full", int'(bus.in_ready), 0);
      end
      @(posedge clk); #2;
      bus.out_ready = 1;
      acc = 3;
      gaps = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!bus.out_valid) gaps++;
         if (bus.in_valid && bus.in_ready) acc++;
         @(posedge clk); #2;
         if (acc == 5) bus.in_valid = 0;
         else set_rand();
      end
      chk("bp_accepts", acc, 5);
      chk("bp_gaps", gaps, 0);
      @(negedge clk);
      chk("bp_count", int'(bus.out_count), int'(16'(base + 16'd5)));
      chk("bp_drained", int'(bus.out_valid), 0);

      // reset with three results in flight
      @(posedge clk); #2;
      bus.out_ready = 0;
      set_rand();
      bus.in_valid = 1;
      repeat (3) @(posedge clk);
      #2;
      bus.in_valid = 0;
      reset_n = 0;
      @(posedge clk); #2;
      reset_n = 1;
      bus.out_ready = 1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(bus.out_valid);
      end
      chk("rst_flush", seen, 0);
      chk("rst_flush_count", int'(bus.out_count), 0);
      one(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), lat);
      chk("lat_after_rst", lat, 3);

      // random traffic with random backpressure
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         set_rand();
      end

      // full-rate stream until the delivered counter wraps
      @(posedge clk); #2;
      bus.out_ready = 1;
      bus.in_valid = 1;
      for (int g = 0; g < 70000 && delivered < 65540; g++) begin
         @(posedge clk); #2;
         set_rand();
      end
      bus.in_valid = 0;
      for (int g = 0; g < 20 && expq.size() > 0; g++) @(negedge clk);
      @(negedge clk);
      chk("drain", expq.size(), 0);
      chk("wrap_reached", int'(delivered >= 65540), 1);
      chk("final_count", int'(bus.out_count), int'(exp_cnt));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sdp_pipe_impl.md
Name: sdp_pipe_impl

Overview:
- Pipelined implementation of the 8-bit select/datapath function that the equivalence harness compares against the single-cycle spec model.
- Three register stages with valid/ready flow control at both ends.
- With output always ready, results appear exactly 3 cycles after acceptance, matching the harness's 3-deep input delay.
- Also maintains a delivered-result counter for bench bookkeeping.

Parameters:
- W, 8, data width of a, b, c and result.
- CNT_W, 16, width of delivered-result counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream presents an operand set this cycle.
- in_ready  output  1  block accepts the operand set this cycle.
- ctl_a  input  1  op select, stages 1 and 3.
- ctl_b  input  1  op select, stage 2.
- a  input  W  operand a.
- b  input  W  operand b.
- c  input  W  operand c.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W  result.
- out_count  output  CNT_W  number of results delivered, modulo 2^CNT_W.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clk edge. While reset_n=0 at an edge:
  - All stage valids clear; all data and ctl registers clear to 0.
  - out_count clears to 0.
  - out_valid=0, out_data=0.
  - in_ready is forced to 0 combinationally while reset_n=0.
- Reset mid-operation discards all in-flight results; nothing is delivered afterwards.
- Accept and deliver:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
- Stage valids v1, v2, v3:
  - adv3 = !v3 | out_ready.
  - adv2 = !v2 | adv3.
  - adv1 = !v1 | adv2.
  - in_ready = adv1 (when reset_n=1).
  - A stage loads from upstream when its adv term is 1; otherwise it holds data and valid.
  - A stage that advances with no upstream valid becomes invalid (bubble).
- Datapath. All arithmetic is unsigned modulo 2^W.
  - S1: p = ctl_a ? a+b : a-b. Carries c, ctl_a, ctl_b forward.
  - S2: q = ctl_b ? low W bits of (p*c) : p^c. Carries ctl_a forward.
  - S3: r = ctl_a ? rotate-left-by-1(q) : q.
  - out_data = S3 register; out_valid = v3.
- Latency: 3 cycles from accept to out_valid with no backpressure.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Backpressure:
  - out_valid=1 & out_ready=0 holds out_data stable.
  - Upstream stages fill bubbles. Once v1, v2 and v3 are all 1, in_ready=0.
  - No result is dropped or duplicated.
  - Ordering is strictly FIFO.
- Simultaneous accept and deliver in a full pipe: in_ready=1 in the same cycle (combinational path from out_ready to in_ready). The pipe shifts by one.
- out_count increments by 1 on each deliver. It wraps from 2^CNT_W-1 to 0.
- Operand inputs are don't-care when in_valid=0.
- Ctl and operand values are captured only on accept.

Optional Feature:
- Macro SDP_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit) = XOR-reduce of out_data, registered alongside S3.
  - Reset value of out_parity is 0.
  - Adds an internal check that out_parity equals the XOR-reduce of out_data whenever out_valid=1.
- When undefined: the port and the check are absent; all other behaviour is identical.

Test Plan:
- reset_n=0 for 2 cycles, then 1 -> out_valid=0, out_data=0, out_count=0; in_ready=0 during reset, 1 after.
- Accept ctl_a=1, ctl_b=1, a=10, b=3, c=5 with out_ready=1 -> 3 cycles later out_valid=1, out_data=0x82 (p=13, q=65, rotl).
- Accept ctl_a=0, ctl_b=0, a=3, b=5, c=0xFF -> out_data=0x01. Accept ctl_a=1, ctl_b=1, a=0xFF, b=2, c=3 -> out_data=0x06 (wrap).
- Backpressure: stream 5 sets with out_ready=0 ->
  - in_ready drops to 0 after 3 accepts.
  - out_data is held.
  - Raising out_ready delivers all 5 in order with no gaps while in_valid stays high.
  - out_count=5.
- Assert reset_n=0 with 3 results in flight -> no out_valid after release; the next accepted set emerges 3 cycles after its accept.
- Preload out_count near wrap (deliver 65535 results, or force via bench) -> the next deliver gives out_count=0.
